// File: rtl/uart_imem_loader.sv
// uart_imem_loader
//
// Boot-image loader between the UART receiver and the IMEM write port.
// Parses a framed image (SYNC, LEN_LO, LEN_HI, N x 4 data bytes LSB-first,
// optional checksum byte) and writes 32-bit words into instruction memory.
// The core is held in reset (cpu_hold) while an image is loading and is
// released once a complete, valid image has been written.
//
// Build option:
//   UART_LOADER_CHECKSUM_EN  when defined, a trailing checksum byte (XOR of
//                            LEN_LO, LEN_HI and every data byte) is expected
//                            and verified. When undefined, no checksum byte
//                            is expected and no XOR logic exists.
//
// Parameters:
//   ADDR_W     IMEM word-address width (1..16); max image is 2^ADDR_W words
//   SYNC_BYTE  frame start marker
//   BOOT_HOLD  reset value of cpu_hold
//
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   rx_done     byte-received level from the UART (asynchronous to clk)
//   rx_data     received byte, stable while rx_done is high
//   imem_we     one-cycle IMEM write strobe
//   imem_addr   IMEM word address, held between writes
//   imem_wdata  IMEM write data, held between writes
//   cpu_hold    core reset/stall request
//   load_done   one-cycle pulse on successful image completion
//   load_err    sticky error flag, cleared by the next SYNC byte
//   dbg_state   current FSM state (debug observation only)
//
// Handshake: byte_valid is a single-cycle qualifier for byte_data. There is
// no backpressure; the FSM consumes every byte_valid in the cycle it occurs,
// which the >= 4 clk spacing of rx_done rising edges guarantees is possible.

module uart_imem_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic        BOOT_HOLD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CHK  = 3'd4,
    ERR  = 3'd5
  } state_t;

  // Largest legal word count; a length of exactly 2^ADDR_W is allowed.
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  // ---------------------------------------------------------------------
  // Byte capture: 2-flop synchronizer, then a registered rising-edge
  // detect. rx_data is sampled on the same edge that raises byte_valid,
  // so a level held high for many cycles produces exactly one byte.
  // ---------------------------------------------------------------------
  logic       rx_sync1;
  logic       rx_sync2;
  logic       rx_prev;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       rx_rise;

  assign rx_rise = rx_sync2 & ~rx_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync1   <= 1'b0;
      rx_sync2   <= 1'b0;
      rx_prev    <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
    end else begin
      rx_sync1   <= rx_done;
      rx_sync2   <= rx_sync1;
      rx_prev    <= rx_sync2;
      byte_valid <= rx_rise;
      if (rx_rise) begin
        byte_data <= rx_data;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Frame parser state
  // ---------------------------------------------------------------------
  state_t            state, state_nxt;
  logic [7:0]        len_lo, len_lo_nxt;
  logic [16:0]       words_left, words_left_nxt;
  logic [ADDR_W-1:0] wptr, wptr_nxt;
  logic [31:0]       asm_word, asm_word_nxt;
  logic [1:0]        byte_cnt, byte_cnt_nxt;
  logic              we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [31:0]       wdata_nxt;
  logic              hold_nxt;
  logic              done_nxt;
  logic              err_nxt;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]        chk_acc, chk_acc_nxt;
`endif

  logic [15:0] len_val;
  logic        len_big;
  logic [31:0] word_full;

  assign len_val   = {byte_data, len_lo};
  assign len_big   = ({1'b0, len_val} > MAX_WORDS);
  // Bytes arrive LSB first, so each new byte enters at the top and the
  // first byte of the word ends up in bits [7:0] after the fourth shift.
  assign word_full = {byte_data, asm_word[31:8]};
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      len_lo     <= 8'h00;
      words_left <= 17'd0;
      wptr       <= '0;
      asm_word   <= 32'h0;
      byte_cnt   <= 2'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0;
      cpu_hold   <= BOOT_HOLD;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      chk_acc    <= 8'h00;
`endif
    end else begin
      state      <= state_nxt;
      len_lo     <= len_lo_nxt;
      words_left <= words_left_nxt;
      wptr       <= wptr_nxt;
      asm_word   <= asm_word_nxt;
      byte_cnt   <= byte_cnt_nxt;
      imem_we    <= we_nxt;
      imem_addr  <= addr_nxt;
      imem_wdata <= wdata_nxt;
      cpu_hold   <= hold_nxt;
      load_done  <= done_nxt;
      load_err   <= err_nxt;
`ifdef UART_LOADER_CHECKSUM_EN
      chk_acc    <= chk_acc_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt      = state;
    len_lo_nxt     = len_lo;
    words_left_nxt = words_left;
    wptr_nxt       = wptr;
    asm_word_nxt   = asm_word;
    byte_cnt_nxt   = byte_cnt;
    we_nxt         = 1'b0;
    addr_nxt       = imem_addr;
    wdata_nxt      = imem_wdata;
    hold_nxt       = cpu_hold;
    done_nxt       = 1'b0;
    err_nxt        = load_err;
`ifdef UART_LOADER_CHECKSUM_EN
    chk_acc_nxt    = chk_acc;
`endif

    case (state)
      IDLE: begin
        if (byte_valid && (byte_data == SYNC_BYTE)) begin
          hold_nxt     = 1'b1;
          err_nxt      = 1'b0;
          addr_nxt     = '0;
          wptr_nxt     = '0;
          byte_cnt_nxt = 2'd0;
`ifdef UART_LOADER_CHECKSUM_EN
          chk_acc_nxt  = 8'h00;
`endif
          state_nxt    = LEN0;
        end
      end

      LEN0: begin
        if (byte_valid) begin
          len_lo_nxt  = byte_data;
`ifdef UART_LOADER_CHECKSUM_EN
          chk_acc_nxt = chk_acc ^ byte_data;
`endif
          state_nxt   = LEN1;
        end
      end

      LEN1: begin
        if (byte_valid) begin
`ifdef UART_LOADER_CHECKSUM_EN
          chk_acc_nxt = chk_acc ^ byte_data;
`endif
          if (len_big) begin
            state_nxt = ERR;
          end else if (len_val == 16'd0) begin
`ifdef UART_LOADER_CHECKSUM_EN
            state_nxt = CHK;
`else
            done_nxt  = 1'b1;
            hold_nxt  = 1'b0;
            state_nxt = IDLE;
`endif
          end else begin
            words_left_nxt = {1'b0, len_val};
            state_nxt      = DATA;
          end
        end
      end

      DATA: begin
        if (byte_valid) begin
`ifdef UART_LOADER_CHECKSUM_EN
          chk_acc_nxt  = chk_acc ^ byte_data;
`endif
          asm_word_nxt = word_full;
          byte_cnt_nxt = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            we_nxt         = 1'b1;
            addr_nxt       = wptr;
            wdata_nxt      = word_full;
            // Wraps to 0 only after the last word of a full-size image.
            wptr_nxt       = wptr + ADDR_W'(1);
            words_left_nxt = words_left - 17'd1;
            if (words_left == 17'd1) begin
`ifdef UART_LOADER_CHECKSUM_EN
              state_nxt = CHK;
`else
              done_nxt  = 1'b1;
              hold_nxt  = 1'b0;
              state_nxt = IDLE;
`endif
            end
          end
        end
      end

`ifdef UART_LOADER_CHECKSUM_EN
      CHK: begin
        if (byte_valid) begin
          if (byte_data == chk_acc) begin
            done_nxt  = 1'b1;
            hold_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            state_nxt = ERR;
          end
        end
      end
`endif

      ERR: begin
        // Already-written words stay in IMEM; the core stays held.
        err_nxt   = 1'b1;
        hold_nxt  = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
